// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, bubble/reset constants
// and the PC increment helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_t;

  localparam logic [15:0] FS_NOP_INSTR = 16'h0800;
  localparam logic [15:0] FS_RESET_PC  = 16'h0000;

  // Sequential instruction address; wraps naturally at 16 bits.
  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic enabled D flip-flop with asynchronous active-low reset.
module dff #(
  parameter int unsigned     W       = 1,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Capture d when enabled; reset value forced asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, flush to a bubble
// (PC_Next kept), or hold. Flush wins over load.
module ifid_reg
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] NOP_INSTR = FS_NOP_INSTR,
  parameter logic [15:0] RESET_PC  = FS_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        flush,
  input  logic [15:0] d_instr,
  input  logic [15:0] d_pc_next,
  output logic [15:0] instr,
  output logic [15:0] pc_next,
  output logic        valid
);

  logic        w_en;
  logic        w_pc_en;
  logic [15:0] w_instr_d;
  logic [0:0]  w_valid_d;
  logic [0:0]  w_valid_q;

  assign w_en      = load | flush;
  assign w_pc_en   = load & ~flush;
  assign w_instr_d = flush ? NOP_INSTR : d_instr;
  assign w_valid_d = flush ? 1'b0 : 1'b1;
  assign valid     = w_valid_q[0];

  dff #(.W(16), .RST_VAL(NOP_INSTR)) u_instr (
    .clk (clk), .rst (rst), .en (w_en), .d (w_instr_d), .q (instr)
  );

  dff #(.W(16), .RST_VAL(RESET_PC)) u_pc_next (
    .clk (clk), .rst (rst), .en (w_pc_en), .d (d_pc_next), .q (pc_next)
  );

  dff #(.W(1), .RST_VAL(1'b0)) u_valid (
    .clk (clk), .rst (rst), .en (w_en), .d (w_valid_d), .q (w_valid_q)
  );

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: single-outstanding request FSM feeding the IF/ID
// register, with stall hold buffer, redirect squash, halt drain and sticky
// fetch-fault handling.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = FS_RESET_PC,
  parameter logic [15:0] NOP_INSTR = FS_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_done,
  input  logic [15:0] imem_rdata,
  input  logic        imem_err,
  output logic [15:0] instr,
  output logic [15:0] PC_Next,
  output logic        fetch_valid,
  output logic        halted,
  output logic        err
);

  fetch_state_t r_state, w_state_nxt;
  logic [15:0]  r_pc, w_pc_nxt;
  logic [15:0]  r_hold_buf, w_hold_buf_nxt;
  logic         r_squash, w_squash_nxt;
  logic         r_halt_pend, w_halt_pend_nxt;
  logic         r_err, w_err_nxt;
  logic         w_req;
  logic         w_ifid_load;
  logic         w_ifid_flush;
  logic [15:0]  w_ifid_instr;
  logic [15:0]  w_pc_plus2;
  logic         w_halt_any;

  assign w_pc_plus2 = pc_incr(r_pc);
  assign w_halt_any = halt | r_halt_pend;

  // Next-state, PC, squash/halt bookkeeping and IF/ID control.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_hold_buf_nxt  = r_hold_buf;
    w_squash_nxt    = r_squash;
    w_halt_pend_nxt = r_halt_pend;
    w_err_nxt       = r_err;
    w_req           = 1'b0;
    w_ifid_load     = 1'b0;
    w_ifid_flush    = 1'b0;
    w_ifid_instr    = imem_rdata;

    unique case (r_state)
      ST_FETCH: begin
        // A halt with no redirect suppresses the request outright.
        w_req = redirect | ~halt;
        if (redirect) begin
          w_pc_nxt        = redirect_pc;
          w_squash_nxt    = 1'b1;
          w_halt_pend_nxt = 1'b0;
          w_ifid_flush    = 1'b1;
          w_state_nxt     = ST_WAIT;
        end else if (halt) begin
          w_state_nxt = ST_HALT;
        end else begin
          w_ifid_flush = ~stall;
          w_state_nxt  = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (redirect) begin
          w_pc_nxt        = redirect_pc;
          w_halt_pend_nxt = 1'b0;
          w_ifid_flush    = 1'b1;
          // A response landing with the redirect is dropped here; otherwise
          // the one still in flight is marked for discard.
          if (imem_done) begin
            w_squash_nxt = 1'b0;
            w_state_nxt  = ST_FETCH;
          end else begin
            w_squash_nxt = 1'b1;
          end
        end else if (imem_done) begin
          w_squash_nxt    = 1'b0;
          w_halt_pend_nxt = 1'b0;
          if (r_squash) begin
            w_ifid_flush = ~stall & ~w_halt_any;
            w_state_nxt  = w_halt_any ? ST_HALT : ST_FETCH;
          end else if (w_halt_any) begin
            w_state_nxt = ST_HALT;
          end else if (imem_err) begin
            w_err_nxt    = 1'b1;
            w_ifid_flush = 1'b1;
            w_state_nxt  = ST_HALT;
          end else if (stall) begin
            w_hold_buf_nxt = imem_rdata;
            w_state_nxt    = ST_HOLD;
          end else begin
            w_ifid_load = 1'b1;
            w_pc_nxt    = w_pc_plus2;
            w_state_nxt = ST_FETCH;
          end
        end else begin
          w_halt_pend_nxt = w_halt_any;
          w_ifid_flush    = ~stall & ~w_halt_any;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          w_pc_nxt     = redirect_pc;
          w_ifid_flush = 1'b1;
          w_state_nxt  = ST_FETCH;
        end else if (halt) begin
          w_state_nxt = ST_HALT;
        end else if (!stall) begin
          w_ifid_load  = 1'b1;
          w_ifid_instr = r_hold_buf;
          w_pc_nxt     = w_pc_plus2;
          w_state_nxt  = ST_FETCH;
        end
      end

      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end

      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // State and control registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_FETCH;
      r_pc        <= RESET_PC;
      r_hold_buf  <= '0;
      r_squash    <= 1'b0;
      r_halt_pend <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_hold_buf  <= w_hold_buf_nxt;
      r_squash    <= w_squash_nxt;
      r_halt_pend <= w_halt_pend_nxt;
      r_err       <= w_err_nxt;
    end
  end

  // Request is gated by reset so nothing is strobed while rst is low.
  assign imem_req  = w_req & rst;
  assign imem_addr = r_pc;
  assign halted    = (r_state == ST_HALT);
  assign err       = r_err;

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR),
    .RESET_PC  (RESET_PC)
  ) u_ifid (
    .clk       (clk),
    .rst       (rst),
    .load      (w_ifid_load),
    .flush     (w_ifid_flush),
    .d_instr   (w_ifid_instr),
    .d_pc_next (w_pc_plus2),
    .instr     (instr),
    .pc_next   (PC_Next),
    .valid     (fetch_valid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized
// run against a program-order reference model with a random-latency memory.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        imem_done = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instr;
  logic [15:0] PC_Next;
  logic        fetch_valid;
  logic        halted;
  logic        err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_done   (imem_done),
    .imem_rdata  (imem_rdata),
    .imem_err    (imem_err),
    .instr       (instr),
    .PC_Next     (PC_Next),
    .fetch_valid (fetch_valid),
    .halted      (halted),
    .err         (err)
  );

  // Memory contents as a function of address.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] p;
    p = a * 16'h9E37;
    return p ^ 16'h1357;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall     = 1'b0;
    redirect  = 1'b0;
    halt      = 1'b0;
    imem_done = 1'b0;
    imem_err  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({instr, PC_Next, fetch_valid, err, halted, imem_req, imem_addr} !==
        {NOP, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_async got instr=%h pcn=%h v=%b err=%b halted=%b req=%b addr=%h want 0800/0000/0/0/0/0/0000",
               instr, PC_Next, fetch_valid, err, halted, imem_req, imem_addr);
    end
    repeat (2) tick();
    rst = 1'b1;
    imem_done  = 1'b1;
    imem_rdata = 16'hDEAD;
    #1;
    checks++;
    if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL reset_first_req got req=%b addr=%h want 1/0000", imem_req, imem_addr);
    end
    tick();
    imem_done = 1'b0;
    checks++;
    if ({instr, fetch_valid, imem_req} !== {NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_spurious_done got instr=%h v=%b req=%b want 0800/0/0", instr, fetch_valid, imem_req);
    end
  endtask

  task automatic test_basic();
    imem_done  = 1'b1;
    imem_rdata = 16'h4021;
    tick();
    imem_done = 1'b0;
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req, imem_addr} !== {16'h4021, 16'h0002, 1'b1, 1'b1, 16'h0002}) begin
      errors++;
      $display("FAIL basic_first got instr=%h pcn=%h v=%b req=%b addr=%h want 4021/0002/1/1/0002",
               instr, PC_Next, fetch_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if ({instr, fetch_valid, imem_req} !== {NOP, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL basic_bubble got instr=%h v=%b req=%b want 0800/0/0", instr, fetch_valid, imem_req);
    end
    imem_done  = 1'b1;
    imem_rdata = 16'h4122;
    tick();
    imem_done = 1'b0;
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req, imem_addr} !== {16'h4122, 16'h0004, 1'b1, 1'b1, 16'h0004}) begin
      errors++;
      $display("FAIL basic_second got instr=%h pcn=%h v=%b req=%b addr=%h want 4122/0004/1/1/0004",
               instr, PC_Next, fetch_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    tick();
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req} !== {16'h4122, 16'h0004, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_fetch_hold got instr=%h pcn=%h v=%b req=%b want 4122/0004/1/0",
               instr, PC_Next, fetch_valid, imem_req);
    end
    imem_done  = 1'b1;
    imem_rdata = 16'hA0A0;
    tick();
    imem_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({instr, PC_Next, fetch_valid, imem_req} !== {16'h4122, 16'h0004, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold_%0d got instr=%h pcn=%h v=%b req=%b want 4122/0004/1/0",
                 i, instr, PC_Next, fetch_valid, imem_req);
      end
      if (i == 0) tick();
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req, imem_addr} !== {16'hA0A0, 16'h0006, 1'b1, 1'b1, 16'h0006}) begin
      errors++;
      $display("FAIL stall_release got instr=%h pcn=%h v=%b req=%b addr=%h want A0A0/0006/1/1/0006",
               instr, PC_Next, fetch_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect();
    stall = 1'b1;
    tick();
    redirect    = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect = 1'b0;
    stall    = 1'b0;
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req} !== {NOP, 16'h0006, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL redirect_flush got instr=%h pcn=%h v=%b req=%b want 0800/0006/0/0",
               instr, PC_Next, fetch_valid, imem_req);
    end
    imem_done  = 1'b1;
    imem_rdata = 16'hBEEF;
    tick();
    imem_done = 1'b0;
    checks++;
    if ({instr, fetch_valid, imem_req, imem_addr} !== {NOP, 1'b0, 1'b1, 16'h0100}) begin
      errors++;
      $display("FAIL redirect_discard got instr=%h v=%b req=%b addr=%h want 0800/0/1/0100",
               instr, fetch_valid, imem_req, imem_addr);
    end
    tick();
    imem_done  = 1'b1;
    imem_rdata = 16'h1234;
    tick();
    imem_done = 1'b0;
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_addr} !== {16'h1234, 16'h0102, 1'b1, 16'h0102}) begin
      errors++;
      $display("FAIL redirect_target got instr=%h pcn=%h v=%b addr=%h want 1234/0102/1/0102",
               instr, PC_Next, fetch_valid, imem_addr);
    end
  endtask

  task automatic test_wrap();
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect   = 1'b0;
    imem_done  = 1'b1;
    imem_rdata = 16'hDEAD;
    tick();
    imem_done = 1'b0;
    checks++;
    if ({imem_req, imem_addr, fetch_valid} !== {1'b1, 16'hFFFE, 1'b0}) begin
      errors++;
      $display("FAIL wrap_req got req=%b addr=%h v=%b want 1/FFFE/0", imem_req, imem_addr, fetch_valid);
    end
    tick();
    imem_done  = 1'b1;
    imem_rdata = 16'h7777;
    tick();
    imem_done = 1'b0;
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req, imem_addr} !== {16'h7777, 16'h0000, 1'b1, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL wrap_pc got instr=%h pcn=%h v=%b req=%b addr=%h want 7777/0000/1/1/0000",
               instr, PC_Next, fetch_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_error();
    tick();
    imem_done  = 1'b1;
    imem_err   = 1'b1;
    imem_rdata = 16'h5555;
    tick();
    imem_done = 1'b0;
    imem_err  = 1'b0;
    checks++;
    if ({err, halted, instr, fetch_valid} !== {1'b1, 1'b1, NOP, 1'b0}) begin
      errors++;
      $display("FAIL error_halt got err=%b halted=%b instr=%h v=%b want 1/1/0800/0", err, halted, instr, fetch_valid);
    end
    for (int i = 0; i < 8; i++) begin
      imem_done = 1'($urandom);
      #1;
      checks++;
      if ({imem_req, err, halted} !== {1'b0, 1'b1, 1'b1}) begin
        errors++;
        $display("FAIL error_quiet_%0d got req=%b err=%b halted=%b want 0/1/1", i, imem_req, err, halted);
      end
      tick();
    end
    apply_reset();
    #1;
    checks++;
    if ({err, halted, imem_req, imem_addr} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      errors++;
      $display("FAIL error_reset got err=%b halted=%b req=%b addr=%h want 0/0/1/0000", err, halted, imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    tick();
    imem_done  = 1'b1;
    imem_rdata = 16'h1111;
    tick();
    imem_done = 1'b0;
    stall     = 1'b1;
    tick();
    stall = 1'b0;
    halt  = 1'b1;
    tick();
    checks++;
    if ({instr, PC_Next, fetch_valid, imem_req, halted} !== {16'h1111, 16'h0002, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL halt_drain got instr=%h pcn=%h v=%b req=%b halted=%b want 1111/0002/1/0/0",
               instr, PC_Next, fetch_valid, imem_req, halted);
    end
    imem_done  = 1'b1;
    imem_rdata = 16'h9999;
    tick();
    imem_done = 1'b0;
    halt      = 1'b0;
    checks++;
    if ({instr, PC_Next, fetch_valid, halted} !== {16'h1111, 16'h0002, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL halt_enter got instr=%h pcn=%h v=%b halted=%b want 1111/0002/1/1",
               instr, PC_Next, fetch_valid, halted);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({imem_req, halted} !== {1'b0, 1'b1}) begin
        errors++;
        $display("FAIL halt_terminal_%0d got req=%b halted=%b want 0/1", i, imem_req, halted);
      end
      tick();
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({halted, imem_req, imem_addr, instr, PC_Next, fetch_valid} !==
        {1'b0, 1'b0, 16'h0000, NOP, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL halt_reset got halted=%b req=%b addr=%h instr=%h pcn=%h v=%b want 0/0/0000/0800/0000/0",
               halted, imem_req, imem_addr, instr, PC_Next, fetch_valid);
    end
    repeat (2) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({imem_req, imem_addr, halted} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++;
      $display("FAIL halt_restart got req=%b addr=%h halted=%b want 1/0000/0", imem_req, imem_addr, halted);
    end
  endtask

  task automatic test_random();
    logic        busy, sq, pending, cur_done, cur_sq, e_valid;
    logic [15:0] mem_a, cur_a, pend_a, exp_addr, e_instr, e_pcn;
    int          cnt, delivered;
    apply_reset();
    busy = 1'b0; sq = 1'b0; pending = 1'b0; cnt = 0; delivered = 0;
    mem_a = '0; pend_a = '0;
    exp_addr = 16'h0000; e_instr = NOP; e_pcn = 16'h0000; e_valid = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      cur_done = 1'b0; cur_sq = 1'b0; cur_a = '0;
      if (busy) begin
        if (cnt == 0) begin
          cur_done = 1'b1; cur_a = mem_a; cur_sq = sq; busy = 1'b0;
        end else begin
          cnt--;
        end
      end
      imem_done   = cur_done;
      imem_rdata  = cur_done ? mem_word(cur_a) : 16'($urandom);
      imem_err    = 1'b0;
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 13) == 0);
      redirect_pc = 16'($urandom) & 16'hFFFE;
      @(negedge clk);
      if (imem_req) begin
        checks++;
        if (busy || cur_done || pending || (imem_addr !== exp_addr)) begin
          errors++;
          $display("FAIL rand_req cyc=%0d got addr=%h want %h (busy=%b done=%b held=%b)",
                   cyc, imem_addr, exp_addr, busy, cur_done, pending);
        end
        busy = 1'b1; cnt = $urandom_range(0, 2); mem_a = imem_addr; sq = 1'b0;
      end
      if (redirect) begin
        if (busy) sq = 1'b1;
        pending  = 1'b0;
        e_instr  = NOP;
        e_valid  = 1'b0;
        exp_addr = redirect_pc;
      end else if (stall) begin
        if (cur_done && !cur_sq) begin
          pending = 1'b1; pend_a = cur_a;
        end
      end else if (cur_done && !cur_sq) begin
        e_instr = mem_word(cur_a); e_pcn = cur_a + 16'd2; e_valid = 1'b1;
        exp_addr = cur_a + 16'd2; delivered++;
      end else if (pending) begin
        pending = 1'b0;
        e_instr = mem_word(pend_a); e_pcn = pend_a + 16'd2; e_valid = 1'b1;
        exp_addr = pend_a + 16'd2; delivered++;
      end else begin
        e_instr = NOP; e_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      checks++;
      if ({instr, PC_Next, fetch_valid} !== {e_instr, e_pcn, e_valid}) begin
        errors++;
        $display("FAIL rand_ifid cyc=%0d got %h/%h/%b want %h/%h/%b",
                 cyc, instr, PC_Next, fetch_valid, e_instr, e_pcn, e_valid);
      end
    end
    idle_inputs();
    checks++;
    if (delivered < 200) begin
      errors++;
      $display("FAIL rand_progress got %0d instructions want at least 200", delivered);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_wrap();
    test_error();
    test_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
